// File: rtl/decode_trace_queue.sv
// decode_trace_queue
// Elastic FIFO between the instruction decoder and the trace printer.
// Every accepted instruction is tagged with its fetch address (RIP) and a
// running sequence number, so the printer sees each instruction in order
// together with the address it was fetched from.
// The decoded fat instruction is carried as an opaque packed vector of
// INS_W bits; the queue never looks inside it.

module decode_trace_queue #(
    parameter int DEPTH = 4,
    parameter int RIP_W = 64,
    parameter int INS_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [RIP_W-1:0]         redirect_rip,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [INS_W-1:0]         dec_ins,
    input  logic [3:0]               dec_len,
    output logic                     prt_valid,
    input  logic                     prt_ready,
    output logic [INS_W-1:0]         prt_ins,
    output logic [RIP_W-1:0]         prt_rip,
    output logic [31:0]              prt_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     len_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [RIP_W-1:0] RIP_ZERO   = {RIP_W{1'b0}};
    localparam logic [INS_W-1:0] INS_ZERO   = {INS_W{1'b0}};
    localparam logic [31:0]      SEQ_ZERO   = 32'd0;
    localparam logic [31:0]      SEQ_ONE    = 32'd1;

    // Entry storage
    logic [INS_W-1:0] r_ins [DEPTH];
    logic [RIP_W-1:0] r_rip [DEPTH];
    logic [31:0]      r_seq [DEPTH];

    // Queue bookkeeping
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [RIP_W-1:0] r_next_rip;
    logic [31:0]      r_next_seq;
    logic             r_len_err;

    // Next-state values
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [RIP_W-1:0] w_next_rip_nxt;
    logic [31:0]      w_next_seq_nxt;
    logic             w_len_err_nxt;

    logic             w_dec_ready;
    logic             w_prt_valid;
    logic             w_push;
    logic             w_pop;
    logic [RIP_W-1:0] w_len_ext;

    // Handshake flags depend only on the registered count, so neither
    // dec_valid nor prt_ready can ripple through to an output. A full queue
    // refuses a push even when the head is being popped in the same cycle.
    assign w_dec_ready = (r_count != FULL_COUNT);
    assign w_prt_valid = (r_count != CNT_ZERO);

    // A redirect squashes both transfers of its cycle.
    assign w_push = dec_valid && w_dec_ready && !redirect_valid;
    assign w_pop  = w_prt_valid && prt_ready && !redirect_valid;

    // Length is zero-extended before being added to the running address.
    assign w_len_ext = {{(RIP_W-4){1'b0}}, dec_len};

    // Compute next pointers, occupancy, running RIP/sequence and error flag.
    always_comb begin
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_next_rip_nxt = r_next_rip;
        w_next_seq_nxt = r_next_seq;
        w_len_err_nxt  = r_len_err;

        if (redirect_valid) begin
            // Flush the queue and restart fetch; sequence and error persist.
            w_head_nxt     = PTR_ZERO;
            w_tail_nxt     = PTR_ZERO;
            w_count_nxt    = CNT_ZERO;
            w_next_rip_nxt = redirect_rip;
        end else begin
            if (w_push) begin
                // Pointer wraps naturally because DEPTH is a power of two.
                w_tail_nxt     = r_tail + PTR_ONE;
                w_next_rip_nxt = r_next_rip + w_len_ext;
                w_next_seq_nxt = r_next_seq + SEQ_ONE;
                if (dec_len == 4'd0) begin
                    w_len_err_nxt = 1'b1;
                end else begin
                    w_len_err_nxt = r_len_err;
                end
            end else begin
                w_tail_nxt     = r_tail;
                w_next_rip_nxt = r_next_rip;
                w_next_seq_nxt = r_next_seq;
            end

            if (w_pop) begin
                w_head_nxt = r_head + PTR_ONE;
            end else begin
                w_head_nxt = r_head;
            end

            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_ONE;
                2'b01:   w_count_nxt = r_count - CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Register the queue bookkeeping; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= PTR_ZERO;
            r_tail     <= PTR_ZERO;
            r_count    <= CNT_ZERO;
            r_next_rip <= RIP_ZERO;
            r_next_seq <= SEQ_ZERO;
            r_len_err  <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_next_rip <= w_next_rip_nxt;
            r_next_seq <= w_next_seq_nxt;
            r_len_err  <= w_len_err_nxt;
        end
    end

    // Write the accepted instruction with its address and sequence tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ins[i] <= INS_ZERO;
                r_rip[i] <= RIP_ZERO;
                r_seq[i] <= SEQ_ZERO;
            end
        end else if (w_push) begin
            r_ins[r_tail] <= dec_ins;
            r_rip[r_tail] <= r_next_rip;
            r_seq[r_tail] <= r_next_seq;
        end
    end

    // Head outputs come straight from storage, so they stay stable while
    // the printer stalls and only change when the head pointer moves.
    assign prt_ins   = r_ins[r_head];
    assign prt_rip   = r_rip[r_head];
    assign prt_seq   = r_seq[r_head];
    assign prt_valid = w_prt_valid;
    assign dec_ready = w_dec_ready;
    assign count     = r_count;
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_decode_trace_queue.sv
// Self-checking bench for decode_trace_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.

module tb_decode_trace_queue;

    localparam int DEPTH = 4;
    localparam int RIP_W = 64;
    localparam int INS_W = 32;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] rip;
        logic [31:0] seq;
    } ent_t;

    logic              clk;
    logic              reset;
    logic              redirect_valid;
    logic [RIP_W-1:0]  redirect_rip;
    logic              dec_valid;
    logic              dec_ready;
    logic [INS_W-1:0]  dec_ins;
    logic [3:0]        dec_len;
    logic              prt_valid;
    logic              prt_ready;
    logic [INS_W-1:0]  prt_ins;
    logic [RIP_W-1:0]  prt_rip;
    logic [31:0]       prt_seq;
    logic [2:0]        count;
    logic              len_err;

    decode_trace_queue #(.DEPTH(DEPTH), .RIP_W(RIP_W), .INS_W(INS_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_rip   (redirect_rip),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_ins        (dec_ins),
        .dec_len        (dec_len),
        .prt_valid      (prt_valid),
        .prt_ready      (prt_ready),
        .prt_ins        (prt_ins),
        .prt_rip        (prt_rip),
        .prt_seq        (prt_seq),
        .count          (count),
        .len_err        (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq[$];
    logic [63:0] m_next_rip;
    logic [31:0] m_next_seq;
    logic        m_len_err;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next_rip = 64'd0;
        m_next_seq = 32'd0;
        m_len_err  = 1'b0;
    endtask

    // Compare every observable output with the model.
    task automatic compare_all();
        check("count", 64'(count), 64'(mq.size()));
        check("prt_valid", 64'(prt_valid), 64'(mq.size() != 0));
        check("dec_ready", 64'(dec_ready), 64'(mq.size() != DEPTH));
        check("len_err", 64'(len_err), 64'(m_len_err));
        if (mq.size() != 0) begin
            check("prt_ins", 64'(prt_ins), 64'(mq[0].ins));
            check("prt_rip", prt_rip, mq[0].rip);
            check("prt_seq", 64'(prt_seq), 64'(mq[0].seq));
        end
    endtask

    // Advance one clock: predict from pre-edge inputs, then check after edge.
    task automatic step();
        bit   push;
        bit   pop;
        ent_t e;
        push = dec_valid && (mq.size() != DEPTH) && !redirect_valid;
        pop  = (mq.size() != 0) && prt_ready && !redirect_valid;
        e.ins = dec_ins;
        e.rip = m_next_rip;
        e.seq = m_next_seq;
        @(posedge clk);
        #1;
        if (redirect_valid) begin
            mq.delete();
            m_next_rip = redirect_rip;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                m_next_rip = m_next_rip + 64'(dec_len);
                m_next_seq = m_next_seq + 32'd1;
                if (dec_len == 4'd0) m_len_err = 1'b1;
            end
        end
        compare_all();
    endtask

    task automatic drive(input logic dv, input logic [3:0] len, input logic pr,
                         input logic rv, input logic [63:0] rrip);
        dec_valid      = dv;
        dec_ins        = $urandom();
        dec_len        = len;
        prt_ready      = pr;
        redirect_valid = rv;
        redirect_rip   = rrip;
    endtask

    task automatic drain();
        drive(1'b0, 4'd1, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (mq.size() != 0) step();
        end
        check("drain_empty", 64'(count), 64'd0);
    endtask

    logic [31:0] saved_seq;

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        reset = 1'b0;
        drive(1'b0, 4'd1, 1'b0, 1'b0, 64'd0);
        #12;
        reset = 1'b1;
        #1;
        // Reset state, including zeroed head storage
        compare_all();
        check("rst_prt_ins", 64'(prt_ins), 64'd0);
        check("rst_prt_rip", prt_rip, 64'd0);
        check("rst_prt_seq", 64'(prt_seq), 64'd0);

        // Lengths 3,5,1 from 0x400000, printer stalled, then drained in order
        drive(1'b0, 4'd1, 1'b0, 1'b1, 64'h400000);
        step();
        drive(1'b1, 4'd3, 1'b0, 1'b0, 64'd0); step();
        drive(1'b1, 4'd5, 1'b0, 1'b0, 64'd0); step();
        drive(1'b1, 4'd1, 1'b0, 1'b0, 64'd0); step();
        check("tp1_count", 64'(count), 64'd3);
        check("tp1_rip0", prt_rip, 64'h400000);
        drive(1'b0, 4'd1, 1'b1, 1'b0, 64'd0);
        step();
        check("tp1_rip1", prt_rip, 64'h400003);
        check("tp1_seq1", 64'(prt_seq), 64'd1);
        step();
        check("tp1_rip2", prt_rip, 64'h400008);
        check("tp1_seq2", 64'(prt_seq), 64'd2);
        step();

        // Fill to DEPTH, hold a fifth offer across a stall, then one pop
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'(i + 2), 1'b0, 1'b0, 64'd0);
            step();
        end
        check("full_ready", 64'(dec_ready), 64'd0);
        drive(1'b1, 4'd7, 1'b0, 1'b0, 64'd0);
        step();
        step();
        check("held_count", 64'(count), 64'd4);
        prt_ready = 1'b1;
        step();
        check("pop_while_full", 64'(count), 64'd3);
        prt_ready = 1'b0;
        step();
        check("fifth_accepted", 64'(count), 64'd4);
        drain();

        // Sustained push+pop from count 2 across pointer wrap
        drive(1'b1, 4'd2, 1'b0, 1'b0, 64'd0); step();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 64'd0); step();
        for (int i = 0; i < 10; i++) begin
            saved_seq = prt_seq;
            drive(1'b1, 4'(1 + (i % 15)), 1'b1, 1'b0, 64'd0);
            step();
            check("steady_count", 64'(count), 64'd2);
            check("steady_seq", 64'(prt_seq), 64'(saved_seq + 32'd1));
        end
        drain();

        // Redirect with count 3 and a same-cycle push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd4, 1'b0, 1'b0, 64'd0);
            step();
        end
        saved_seq = m_next_seq;
        drive(1'b1, 4'd4, 1'b1, 1'b1, 64'h1000);
        step();
        check("redir_count", 64'(count), 64'd0);
        check("redir_valid", 64'(prt_valid), 64'd0);
        drive(1'b1, 4'd2, 1'b0, 1'b0, 64'd0);
        step();
        check("redir_rip", prt_rip, 64'h1000);
        check("redir_seq", 64'(prt_seq), 64'(saved_seq));
        drain();

        // Address wrap and zero-length entries
        drive(1'b0, 4'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 64'd0); step();
        check("wrap_rip0", prt_rip, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 4'd1, 1'b1, 1'b0, 64'd0); step();
        check("wrap_rip1", prt_rip, 64'h2);
        drive(1'b1, 4'd0, 1'b1, 1'b0, 64'd0); step();
        check("len0_err", 64'(len_err), 64'd1);
        check("len0_rip", prt_rip, 64'h3);
        drive(1'b1, 4'd2, 1'b1, 1'b0, 64'd0); step();
        check("len0_reuse", prt_rip, 64'h3);
        drain();

        // Asynchronous reset mid-stream with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd5, 1'b0, 1'b0, 64'd0);
            step();
        end
        drive(1'b0, 4'd1, 1'b0, 1'b0, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(prt_valid), 64'd0);
        check("arst_ready", 64'(dec_ready), 64'd1);
        check("arst_len_err", 64'(len_err), 64'd0);
        check("arst_prt_rip", prt_rip, 64'd0);
        check("arst_prt_seq", 64'(prt_seq), 64'd0);
        check("arst_prt_ins", 64'(prt_ins), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        compare_all();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            dec_valid      = ($urandom_range(0, 3) != 0);
            dec_ins        = $urandom();
            dec_len        = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            prt_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_rip   = {$urandom(), $urandom()};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_trace_queue.md
# decode_trace_queue

Elastic buffer between the instruction decoder and the instruction printer. Accepts one decoded `fat_instruction_t` per cycle with its byte length and tags each entry with its instruction address (RIP) and a sequence number. Presents entries in order to the printer over a valid/ready handshake. Decouples decoder throughput from trace-output back-pressure and gives the printer the address of every instruction it emits.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, ≥2.
- `RIP_W`, 64: instruction-address width.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserting it (0) immediately clears all state; deassertion is synchronous to `clk` at the system level.
- `redirect_valid`  in  1  load a new fetch address and flush the queue.
- `redirect_rip`  in  RIP_W  new address, valid with `redirect_valid`.
- `dec_valid`  in  1  decoder offers an instruction.
- `dec_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `dec_ins`  in  fat_instruction_t  decoded instruction.
- `dec_len`  in  4  instruction length in bytes, legal 1..15.
- `prt_valid`  out  1  head entry available; equals `count != 0`.
- `prt_ready`  in  1  printer consumes head.
- `prt_ins`  out  fat_instruction_t  head instruction.
- `prt_rip`  out  RIP_W  address of head instruction.
- `prt_seq`  out  32  sequence number of head instruction.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `len_err`  out  1  sticky: an instruction with `dec_len == 0` was accepted.

## Operation
- Storage: circular array of DEPTH entries {ins, rip, seq}; head/tail pointers $clog2(DEPTH) bits wrapping modulo DEPTH; separate `count`.
- Push when `dec_valid && dec_ready && !redirect_valid`: entry ← {dec_ins, next_rip, next_seq}; `next_rip` ← `next_rip + dec_len` (zero-extended, modulo 2^RIP_W); `next_seq` ← `next_seq + 1` (modulo 2^32); tail advances.
- Pop when `prt_valid && prt_ready && !redirect_valid`: head advances.
- Simultaneous push and pop: count unchanged; both pointers advance. When full, `dec_ready = 0` regardless of `prt_ready` (no same-cycle pass-through of a freed slot).
- Redirect: head, tail, count ← 0; `next_rip` ← `redirect_rip`. Same-cycle `dec_valid` and `prt_ready` are ignored (push dropped, no pop). `next_seq` and `len_err` are not cleared.
- `dec_len == 0`: entry still accepted, `next_rip` does not advance, `len_err` ← 1 and held until reset.
- `prt_ins/prt_rip/prt_seq` are driven directly from the head entry; they are meaningful only while `prt_valid = 1`.
- Reset values: count 0, pointers 0, `next_rip` 0, `next_seq` 0, `len_err` 0, all entry storage 0. Consequently `prt_valid` = 0, `dec_ready` = 1, and `prt_ins/prt_rip/prt_seq` = 0.
- Reset asserted mid-operation discards all entries immediately. There is no partial state.

## Timing
- Push-to-visible latency is 1 cycle: an entry accepted at edge N has `prt_valid = 1` after edge N.
- Sustained throughput is 1 instruction/cycle when `prt_ready` is held at 1 and count < DEPTH.
- `dec_ready` and `prt_valid` are decoded from registered `count` only. There is no combinational path from `dec_valid` or `prt_ready` to any output.
- Handshake rules: the upstream holds `dec_ins` and `dec_len` stable while `dec_valid && !dec_ready`. The queue holds head outputs stable while `prt_valid && !prt_ready`.
- Redirect takes effect at the edge it is sampled. `prt_valid = 0` is guaranteed in the following cycle.

## Test plan
- Reset, then `redirect_rip=0x400000`; push lens 3,5,1 with `prt_ready=0` → count 3; then `prt_ready=1` → prt_rip 0x400000, 0x400003, 0x400008 with seq 0,1,2 on consecutive cycles.
- Fill DEPTH=4 with `prt_ready=0` → `dec_ready=0` at count 4; the 5th offer is held until one pop, then accepted with no loss or duplication.
- Continuous push+pop for 10 cycles from count 2 → count stays 2; seq strictly increments; pointers wrap cleanly past DEPTH.
- Redirect to 0x1000 with count 3 and `dec_valid=1` in the same cycle → next cycle count 0, `prt_valid=0`; the next push carries rip 0x1000 and seq continuing from the last assigned value + 1 (the dropped push consumes no seq).
- `next_rip=0xFFFF_FFFF_FFFF_FFFE`, push len 4 then len 1 → second entry rip 0x2 (wrap). Then push len 0 → `len_err=1`, and the following entry reuses the same rip.
- Assert reset mid-stream with count 3 → outputs return to reset values asynchronously, before the next clock edge.
